collision_scan_sequencer: RTL and testbench

Time-multiplexed replacement for the fully parallel platform/doodle landing check. Once per frame it walks the platform table one entry per cycle through a registered read port, applies the landing rule and reports the ground platform. It sits between the platform table (platform generator/scroller) and the doodle physics block, which consumes ground_y/ground_x/ground_id.

---
 rtl/collision_scan_sequencer.sv | 154 +++++++++++++++
 tb/tb_collision_scan_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scan_sequencer.sv
// Sequential platform landing check: walks the platform table once per frame through a
// registered read port and reports the highest-index platform the doodle lands on.
module collision_scan_sequencer #(
  parameter int N_PLAT     = 93,
  parameter int IDX_W      = 7,
  parameter int DOODLE_H   = 80,
  parameter int Y_TOL      = 30,
  parameter int X_LO       = 61,
  parameter int X_HI       = 80,
  parameter int GROUND_RST = 767
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic [10:0]             doodle_x,
  input  logic [9:0]              doodle_y,
  output logic                    rd_en,
  output logic [IDX_W-1:0]        rd_idx,
  input  logic signed [10:0]      rd_y,
  input  logic signed [10:0]      rd_x,
  input  logic                    rd_active,
  output logic                    busy,
  output logic                    scan_done,
  output logic                    hit,
  output logic [9:0]              ground_y,
  output logic signed [10:0]      ground_x,
  output logic [IDX_W-1:0]        ground_id
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_PLAT - 1);
  localparam logic signed [12:0] H_S      = 13'(DOODLE_H);
  localparam logic signed [12:0] TOL_S    = 13'(Y_TOL);
  localparam logic signed [12:0] XLO_S    = 13'(X_LO);
  localparam logic signed [12:0] XHI_S    = 13'(X_HI);

  state_t state, state_nxt;

  logic [10:0]             dx;
  logic [9:0]              dy, y_prev;
  logic                    falling;
  logic                    vld;
  logic [IDX_W-1:0]        idx_q;
  logic                    best_valid;
  logic [9:0]              best_y;
  logic signed [10:0]      best_x;
  logic [IDX_W-1:0]        best_id;

  logic signed [10:0]      dy_delta;
  logic signed [12:0]      dx_s, feet, py, px;
  logic                    match;
  logic                    fin_valid;
  logic [9:0]              fin_y;
  logic signed [10:0]      fin_x;
  logic [IDX_W-1:0]        fin_id;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_tick) state_nxt = READ;
      READ:    if (rd_idx == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Landing rule evaluated in 13-bit signed so negative platform coordinates compare correctly.
  always_comb begin
    dy_delta = 11'(doodle_y) - 11'(y_prev);
    dx_s     = {2'b00, dx};
    feet     = {3'b000, dy} + H_S;
    py       = {{2{rd_y[10]}}, rd_y};
    px       = {{2{rd_x[10]}}, rd_x};
    match    = vld && rd_active && falling &&
               (py <= feet) && (feet <= py + TOL_S) &&
               (px - XLO_S <= dx_s) && (dx_s <= px + XHI_S);
    fin_valid = best_valid | match;
    fin_y     = match ? rd_y[9:0] : best_y;
    fin_x     = match ? rd_x      : best_x;
    fin_id    = match ? idx_q     : best_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en      <= 1'b0;
      rd_idx     <= '0;
      vld        <= 1'b0;
      idx_q      <= '0;
      scan_done  <= 1'b0;
      hit        <= 1'b0;
      ground_y   <= 10'(GROUND_RST);
      ground_x   <= '0;
      ground_id  <= '0;
      y_prev     <= doodle_y;
      dx         <= '0;
      dy         <= '0;
      falling    <= 1'b0;
      best_valid <= 1'b0;
      best_y     <= '0;
      best_x     <= '0;
      best_id    <= '0;
    end else begin
      vld        <= rd_en;
      idx_q      <= rd_idx;
      scan_done  <= 1'b0;
      hit        <= 1'b0;
      best_valid <= fin_valid;
      best_y     <= fin_y;
      best_x     <= fin_x;
      best_id    <= fin_id;
      case (state)
        IDLE: if (frame_tick) begin
          dx         <= doodle_x;
          dy         <= doodle_y;
          falling    <= (dy_delta > 11'sd0);
          y_prev     <= doodle_y;
          best_valid <= 1'b0;
          rd_en      <= 1'b1;
          rd_idx     <= '0;
        end
        READ: begin
          if (rd_idx == LAST_IDX) begin
            rd_en  <= 1'b0;
            rd_idx <= '0;
          end else begin
            rd_idx <= rd_idx + IDX_W'(1);
          end
        end
        // The last entry is still being evaluated here, so results come from the merge path.
        DRAIN: begin
          scan_done <= 1'b1;
          hit       <= fin_valid;
          if (fin_valid) begin
            ground_y  <= fin_y;
            ground_x  <= fin_x;
            ground_id <= fin_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scan_sequencer.sv
// Directed bench for collision_scan_sequencer: a registered platform table model and
// hand-computed landing results for window edges, priority, latency and abort cases.
module tb_collision_scan_sequencer;

  localparam int N = 93;

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_tick;
  logic [10:0]        doodle_x;
  logic [9:0]         doodle_y;
  logic               rd_en;
  logic [6:0]         rd_idx;
  logic signed [10:0] rd_y, rd_x;
  logic               rd_active;
  logic               busy, scan_done, hit;
  logic [9:0]         ground_y;
  logic signed [10:0] ground_x;
  logic [6:0]         ground_id;

  logic signed [10:0] ty [N];
  logic signed [10:0] tx [N];
  logic               ta [N];

  int n_checks = 0;
  int n_fail   = 0;

  collision_scan_sequencer dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .doodle_x(doodle_x), .doodle_y(doodle_y),
    .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_y(rd_y), .rd_x(rd_x), .rd_active(rd_active),
    .busy(busy), .scan_done(scan_done), .hit(hit),
    .ground_y(ground_y), .ground_x(ground_x), .ground_id(ground_id)
  );

  always #5 clk = ~clk;

  // Platform table with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_y      <= ty[rd_idx];
      rd_x      <= tx[rd_idx];
      rd_active <= ta[rd_idx];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_tab();
    for (int i = 0; i < N; i++) begin
      ty[i] = 11'sd0;
      tx[i] = 11'sd0;
      ta[i] = 1'b0;
    end
  endtask

  task automatic set_ent(input int i, input logic signed [10:0] y, input logic signed [10:0] x,
                         input logic a);
    ty[i] = y;
    tx[i] = x;
    ta[i] = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one scan from idle; inputs are scrambled mid-scan to prove they were latched.
  task automatic do_scan(input string tag, input logic [10:0] dx, input logic [9:0] dy,
                         input logic exp_hit, input logic [9:0] ey,
                         input logic signed [10:0] ex, input logic [6:0] eid,
                         input bit busy_tick, input bit done_tick);
    int k, en_cnt, max_idx, extra;
    doodle_x   = dx;
    doodle_y   = dy;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    k = 1;
    check({tag, ".first_rd_en"}, rd_en, 1);
    check({tag, ".first_idx"}, rd_idx, 0);
    check({tag, ".busy_start"}, busy, 1);
    en_cnt  = rd_en ? 1 : 0;
    max_idx = rd_idx;
    while (!scan_done && k < 200) begin
      step();
      k++;
      if (k == 5) begin
        doodle_x = 11'd0;
        doodle_y = 10'd0;
      end
      if (busy_tick && k == 10) begin
        frame_tick = 1'b1;
        doodle_y   = 10'd1000;
        doodle_x   = 11'd900;
      end
      if (k == 11) frame_tick = 1'b0;
      if (rd_en) en_cnt++;
      if (int'(rd_idx) > max_idx) max_idx = rd_idx;
    end
    check({tag, ".latency"}, k, N + 2);
    check({tag, ".rd_en_cycles"}, en_cnt, N);
    check({tag, ".max_idx"}, max_idx, N - 1);
    check({tag, ".busy_done"}, busy, 1);
    check({tag, ".hit"}, hit, exp_hit);
    check({tag, ".ground_y"}, ground_y, ey);
    check({tag, ".ground_x"}, ground_x, ex);
    check({tag, ".ground_id"}, ground_id, eid);
    if (done_tick) frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check({tag, ".done_pulse"}, scan_done, 0);
    check({tag, ".hit_clear"}, hit, 0);
    check({tag, ".busy_idle"}, busy, 0);
    check({tag, ".rd_en_idle"}, rd_en, 0);
    check({tag, ".idx_idle"}, rd_idx, 0);
    check({tag, ".ground_hold"}, ground_id, eid);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (scan_done || busy) extra++;
    end
    check({tag, ".quiet"}, extra, 0);
  endtask

  initial begin
    int dones;
    rst        = 1'b1;
    frame_tick = 1'b0;
    doodle_x   = 11'd0;
    doodle_y   = 10'd300;
    clear_tab();
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst.ground_y", ground_y, 767);
    check("rst.ground_x", ground_x, 0);
    check("rst.ground_id", ground_id, 0);
    check("rst.busy", busy, 0);
    check("rst.rd_en", rd_en, 0);
    check("rst.rd_idx", rd_idx, 0);
    check("rst.hit", hit, 0);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (scan_done) dones++;
    end
    check("idle.no_done", dones, 0);

    // Basic landing: feet 410 on platform top 410.
    set_ent(5, 11'sd410, 11'sd150, 1'b1);
    do_scan("land", 11'd200, 10'd330, 1'b1, 10'd410, 11'sd150, 7'd5, 0, 0);
    do_scan("land2", 11'd200, 10'd340, 1'b1, 10'd410, 11'sd150, 7'd5, 0, 0);
    do_scan("rising", 11'd200, 10'd320, 1'b0, 10'd410, 11'sd150, 7'd5, 0, 0);

    clear_tab(); set_ent(7, 11'sd410, 11'sd150, 1'b1);
    do_scan("y_top", 11'd200, 10'd330, 1'b1, 10'd410, 11'sd150, 7'd7, 0, 0);
    clear_tab(); set_ent(8, 11'sd390, 11'sd150, 1'b1);
    do_scan("y_tol", 11'd200, 10'd340, 1'b1, 10'd390, 11'sd150, 7'd8, 0, 0);
    clear_tab(); set_ent(9, 11'sd399, 11'sd150, 1'b1);
    do_scan("y_over", 11'd200, 10'd350, 1'b0, 10'd390, 11'sd150, 7'd8, 0, 0);
    clear_tab(); set_ent(10, 11'sd440, 11'sd300, 1'b1);
    do_scan("x_lo", 11'd239, 10'd360, 1'b1, 10'd440, 11'sd300, 7'd10, 0, 0);
    clear_tab(); set_ent(11, 11'sd450, 11'sd300, 1'b1);
    do_scan("x_lo_out", 11'd238, 10'd370, 1'b0, 10'd440, 11'sd300, 7'd10, 0, 0);
    clear_tab(); set_ent(12, 11'sd460, 11'sd300, 1'b1);
    do_scan("x_hi", 11'd380, 10'd380, 1'b1, 10'd460, 11'sd300, 7'd12, 0, 0);
    clear_tab(); set_ent(13, 11'sd470, 11'sd300, 1'b1);
    do_scan("x_hi_out", 11'd381, 10'd390, 1'b0, 10'd460, 11'sd300, 7'd12, 0, 0);
    clear_tab(); set_ent(14, 11'sd480, 11'sd300, 1'b0);
    do_scan("inactive", 11'd350, 10'd400, 1'b0, 10'd460, 11'sd300, 7'd12, 0, 0);

    // Two matches: the higher index wins.
    clear_tab(); set_ent(3, 11'sd490, 11'sd100, 1'b1); set_ent(90, 11'sd480, 11'sd120, 1'b1);
    do_scan("multi", 11'd150, 10'd410, 1'b1, 10'd480, 11'sd120, 7'd90, 0, 0);
    clear_tab(); set_ent(92, 11'sd500, -11'sd40, 1'b1);
    do_scan("neg_x_last", 11'd10, 10'd420, 1'b1, 10'd500, -11'sd40, 7'd92, 0, 0);

    // Tick during the scan must not disturb it nor move y_prev (next scan still falling).
    clear_tab(); set_ent(0, 11'sd505, 11'sd0, 1'b1);
    do_scan("busy_tick", 11'd20, 10'd430, 1'b1, 10'd505, 11'sd0, 7'd0, 1, 0);
    clear_tab(); set_ent(1, 11'sd500, 11'sd0, 1'b1);
    do_scan("done_tick", 11'd20, 10'd440, 1'b1, 10'd500, 11'sd0, 7'd1, 0, 1);

    // Reset in the middle of a scan aborts it.
    clear_tab(); set_ent(2, 11'sd530, 11'sd0, 1'b1);
    doodle_x   = 11'd20;
    doodle_y   = 10'd450;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (39) step();
    check("abort.busy_before", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort.ground_y", ground_y, 767);
    check("abort.ground_x", ground_x, 0);
    check("abort.ground_id", ground_id, 0);
    check("abort.busy", busy, 0);
    check("abort.rd_en", rd_en, 0);
    check("abort.rd_idx", rd_idx, 0);
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (scan_done || hit) dones++;
    end
    check("abort.no_done", dones, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
